spi_share_arb: RTL

//  Shares one SPI_mstr16 between two requesters: req0 = inertial interface, req1 = A2D interface.

---
 rtl/spi_arb_pkg.sv | 35 +++
 rtl/spi_req_slot.sv | 65 ++++++
 rtl/spi_share_arb.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the two-requester SPI master arbiter.
package spi_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

  // Requester indices: 0 = inertial interface, 1 = A2D interface.
  localparam int REQ_INERT = 0;
  localparam int REQ_A2D   = 1;

  // Default idle-hold budget for a locked owner.
  localparam int HOLD_MAX_DEF = 16;

  // Round-robin pick between two eligible requesters.
  // Returns the index to grant; the caller decides whether anyone is eligible.
  function automatic logic rr_pick(input logic elig0,
                                   input logic elig1,
                                   input logic last_gnt);
    logic pick;
    if (elig0 && elig1) begin
      pick = ~last_gnt;
    end else if (elig1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/spi_req_slot.sv
// One requester slot: remembers a pending request, its command and the
// level done flag reported back to that requester.
//
// Requester handshake: wrt_i is a one-cycle request strobe that carries
// cmd_i. A strobe is accepted only when no request is already pending
// (a second strobe while pending is dropped and the first command kept).
// Acceptance clears done_o; done_o rises when the arbiter reports the
// transaction complete and stays high until the next accepted strobe.
module spi_req_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_i,
  input  logic [15:0] cmd_i,
  input  logic        grant_i,
  input  logic        set_done_i,
  output logic        pend_o,
  output logic [15:0] cmd_buf_o,
  output logic        done_o
);
  import spi_arb_pkg::*;

  logic        pend_q, pend_d;
  logic [15:0] cmd_buf_q, cmd_buf_d;
  logic        done_q, done_d;
  logic        accept;

  assign accept = wrt_i & ~pend_q;

  // Next-state: completion is applied first so a same-cycle new request
  // leaves done low; a grant consumes the pending request.
  always_comb begin
    pend_d    = pend_q;
    cmd_buf_d = cmd_buf_q;
    done_d    = done_q;
    if (set_done_i) begin
      done_d = 1'b1;
    end
    if (accept) begin
      pend_d    = 1'b1;
      cmd_buf_d = cmd_i;
      done_d    = 1'b0;
    end
    if (grant_i) begin
      pend_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      cmd_buf_q <= 16'h0000;
      done_q    <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      cmd_buf_q <= cmd_buf_d;
      done_q    <= done_d;
    end
  end

  assign pend_o    = pend_q;
  assign cmd_buf_o = cmd_buf_q;
  assign done_o    = done_q;

endmodule

// File: rtl/spi_share_arb.sv
// Shares one SPI_mstr16 between the inertial (req0) and A2D (req1)
// interfaces. Picks an owner, forwards its command, routes the master's
// SS_n to the owner's slave only, and lets a locked owner keep the bus
// for back-to-back transactions up to HOLD_MAX idle cycles.
//
// Master handshake: m_wrt is a one-cycle start strobe with m_cmd stable
// from the same cycle. Completion is the rising edge of the level m_done;
// a done still high from the previous transfer is not a completion.
module spi_share_arb
  import spi_arb_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0 (inertial)
  input  logic        wrt0,
  input  logic [15:0] cmd0,
  input  logic        lock0,
  output logic        done0,
  // requester 1 (A2D)
  input  logic        wrt1,
  input  logic [15:0] cmd1,
  input  logic        lock1,
  output logic        done1,
  // shared read data
  output logic [15:0] rd_data,
  // SPI master side
  output logic        m_wrt,
  output logic [15:0] m_cmd,
  input  logic        m_done,
  input  logic [15:0] m_rd_data,
  input  logic        m_SS_n,
  // slave selects
  output logic        SS_n0,
  output logic        SS_n1,
  // debug: current FSM state
  output arb_state_t  state_o
);

  localparam int             HCW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);
  localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1);

  arb_state_t     state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_gnt_q, last_gnt_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]    m_cmd_q, m_cmd_d;
  logic [15:0]    rd_data_q, rd_data_d;
  logic           m_done_q;
  logic           done_rise;

  logic           pend0, pend1;
  logic [15:0]    buf0, buf1;
  logic           gnt0, gnt1;
  logic           set_done0, set_done1;

  logic           elig0, elig1;
  logic [15:0]    sel0, sel1;
  logic           own_elig, own_lock;
  logic [15:0]    own_cmd;
  logic           arb;
  logic           pick;

  spi_req_slot u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_i      (wrt0),
    .cmd_i      (cmd0),
    .grant_i    (gnt0),
    .set_done_i (set_done0),
    .pend_o     (pend0),
    .cmd_buf_o  (buf0),
    .done_o     (done0)
  );

  spi_req_slot u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrt_i      (wrt1),
    .cmd_i      (cmd1),
    .grant_i    (gnt1),
    .set_done_i (set_done1),
    .pend_o     (pend1),
    .cmd_buf_o  (buf1),
    .done_o     (done1)
  );

  // A requester is eligible with a pending request or a strobe this cycle;
  // a pending command takes precedence because a strobe on top of it is dropped.
  assign elig0 = pend0 | wrt0;
  assign elig1 = pend1 | wrt1;
  assign sel0  = pend0 ? buf0 : cmd0;
  assign sel1  = pend1 ? buf1 : cmd1;

  assign own_elig = owner_q ? elig1 : elig0;
  assign own_lock = owner_q ? lock1 : lock0;
  assign own_cmd  = owner_q ? sel1  : sel0;

  assign done_rise = m_done & ~m_done_q;

  // FSM next-state, grant, completion and hold-counter logic.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    hold_cnt_d = hold_cnt_q;
    m_cmd_d    = m_cmd_q;
    rd_data_d  = rd_data_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    set_done0  = 1'b0;
    set_done1  = 1'b0;
    arb        = 1'b0;
    pick       = 1'b0;

    case (state_q)
      IDLE: begin
        arb = 1'b1;
      end
      ISSUE: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (done_rise) begin
          rd_data_d  = m_rd_data;
          set_done0  = ~owner_q;
          set_done1  = owner_q;
          last_gnt_d = owner_q;
          hold_cnt_d = '0;
          state_d    = own_lock ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (own_elig) begin
          // Owner keeps the bus: issue its next command directly.
          gnt0       = ~owner_q;
          gnt1       = owner_q;
          m_cmd_d    = own_cmd;
          hold_cnt_d = '0;
          state_d    = ISSUE;
        end else if (!own_lock) begin
          // Voluntary release arbitrates in this same cycle.
          arb = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (arb) begin
      state_d = IDLE;
      if (elig0 || elig1) begin
        pick    = rr_pick(elig0, elig1, last_gnt_q);
        owner_d = pick;
        m_cmd_d = pick ? sel1 : sel0;
        gnt0    = ~pick;
        gnt1    = pick;
        state_d = ISSUE;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      hold_cnt_q <= '0;
      m_cmd_q    <= 16'h0000;
      rd_data_q  <= 16'h0000;
      m_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      hold_cnt_q <= hold_cnt_d;
      m_cmd_q    <= m_cmd_d;
      rd_data_q  <= rd_data_d;
      m_done_q   <= m_done;
    end
  end

  assign m_wrt   = (state_q == ISSUE);
  assign m_cmd   = m_cmd_q;
  assign rd_data = rd_data_q;
  assign state_o = state_q;

  // Only the current owner ever sees the master's slave select.
  assign SS_n0 = ((owner_q == 1'b0) && (state_q != IDLE)) ? m_SS_n : 1'b1;
  assign SS_n1 = ((owner_q == 1'b1) && (state_q != IDLE)) ? m_SS_n : 1'b1;

endmodule
